// File: rtl/vga_sync.sv
// VGA sync generator: vertical line counter driven by an upstream
// horizontal counter, plus registered sync, blanking and pixel position.
module vga_sync #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic [9:0] Hcount,
    input  logic       Roll_over,
    output logic [9:0] Vcount,
    output logic       Hsync,
    output logic       Vsync,
    output logic       Video_on,
    output logic [9:0] Col,
    output logic [9:0] Row,
    output logic       Frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_VIS_L = 10'(H_VISIBLE);
    localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_VIS_L = 10'(V_VISIBLE);
    localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_TOT_L = 10'(H_TOTAL);

    logic [9:0] vcount_q, vcount_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       frame_start_q, frame_start_d;

    logic in_hsync;
    logic in_vsync;
    logic wrap;

    always_comb begin
        // Out-of-range Hcount fails every window below, so it reads as blanking.
        in_hsync = (Hcount >= HS_BEG) && (Hcount <= HS_END)
                   && (Hcount < H_TOT_L);
        in_vsync = (vcount_q >= VS_BEG) && (vcount_q <= VS_END);
        wrap     = Roll_over && (vcount_q == V_LAST);

        vcount_d = vcount_q;
        if (Roll_over) begin
            vcount_d = wrap ? 10'd0 : vcount_q + 10'd1;
        end

        hsync_d       = in_hsync ? SYNC_POL : ~SYNC_POL;
        vsync_d       = in_vsync ? SYNC_POL : ~SYNC_POL;
        video_on_d    = (Hcount < H_VIS_L) && (vcount_q < V_VIS_L);
        col_d         = video_on_d ? Hcount : 10'd0;
        row_d         = video_on_d ? vcount_q : 10'd0;
        frame_start_d = wrap;
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            vcount_q      <= 10'd0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            col_q         <= col_d;
            row_q         <= row_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign Vcount      = vcount_q;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign Video_on    = video_on_q;
    assign Col         = col_q;
    assign Row         = row_q;
    assign Frame_start = frame_start_q;

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_VISIBLE, default 640, meaning visible pixels per line.
REQ-002 Parameter H_FP, default 16, meaning horizontal front porch in pixel clocks.
REQ-003 Parameter H_SYNC, default 96, meaning horizontal sync width in pixel clocks.
REQ-004 Parameter H_BP, default 48, meaning horizontal back porch; H_TOTAL = sum of the four H values = 800.
REQ-005 Parameters V_VISIBLE, V_FP, V_SYNC and V_BP, defaults 480, 10, 2 and 33 lines; V_TOTAL = their sum = 525.
REQ-006 Parameter SYNC_POL, default 0, meaning active level of Hsync/Vsync; the inactive level is ~SYNC_POL.
REQ-007 Clock  input  1  pixel clock; all state updates on its rising edge.
REQ-008 Clear  input  1  reset, synchronous, active-low.
REQ-009 Hcount  input  10  horizontal position from the upstream horizontal counter, 0..H_TOTAL-1.
REQ-010 Roll_over  input  1  from the upstream horizontal counter; high for the single Clock in which Hcount = H_TOTAL-1.
REQ-011 Vcount  output  10  current line number, 0..V_TOTAL-1.
REQ-012 Hsync  output  1  horizontal sync, registered.
REQ-013 Vsync  output  1  vertical sync, registered.
REQ-014 Video_on  output  1  high while the pixel is in the visible region, registered.
REQ-015 Col  output  10  visible pixel column, registered.
REQ-016 Row  output  10  visible pixel row, registered.
REQ-017 Frame_start  output  1  one-Clock pulse marking the start of a frame.

Function
REQ-018 The vertical counter SHALL increment Vcount on every rising edge at which Roll_over=1, and SHALL hold Vcount otherwise.
REQ-019 Vcount SHALL wrap from V_TOTAL-1 to 0 on a Roll_over edge.
REQ-020 If Roll_over is held high across several edges, Vcount SHALL increment once per edge; there is no edge detection.
REQ-021 Hsync SHALL equal SYNC_POL exactly when the Hcount sampled on the previous edge lies in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751]; otherwise it SHALL equal ~SYNC_POL.
REQ-022 Vsync SHALL equal SYNC_POL exactly when the Vcount register value before the edge lies in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] = [490,491].
REQ-023 Video_on SHALL be 1 exactly when the sampled Hcount < H_VISIBLE and Vcount < V_VISIBLE.
REQ-024 Col SHALL equal the sampled Hcount while Video_on=1, and 0 otherwise; Row SHALL equal Vcount while Video_on=1, and 0 otherwise.
REQ-025 The latency from the Hcount/Vcount values to Hsync, Vsync, Video_on, Col and Row SHALL be exactly one Clock.
REQ-026 Frame_start SHALL be 1 for exactly one Clock, namely the Clock following the edge at which Vcount wraps to 0.
REQ-027 Any Hcount >= H_TOTAL SHALL be treated as blanking: Video_on=0, Hsync inactive, Col=0.
REQ-028 All comparison boundaries SHALL be derived from the parameters; no hard-coded constants are permitted.

Reset
REQ-029 While Clear=0 at a rising edge, the block SHALL set Vcount=0, Hsync=~SYNC_POL, Vsync=~SYNC_POL, Video_on=0, Row=0, Col=0 and Frame_start=0.
REQ-030 Reset SHALL take priority over Roll_over.
REQ-031 Reset asserted mid-frame SHALL abort the frame; counting SHALL resume from line 0 on the first Roll_over after Clear returns to 1.
REQ-032 Reset SHALL NOT generate a Frame_start pulse.

Verification
REQ-033 Reset: hold Clear=0 for 2 Clocks with Roll_over=1 -> Vcount=0, Hsync=Vsync=1, Video_on=0, Row=Col=0.
REQ-034 Horizontal line: drive Hcount 0..799 with Roll_over at 799 and Vcount=0 -> Video_on=1 for registered Hcount 0..639; Col tracks Hcount; Hsync=0 for exactly 96 Clocks (Hcount 656..751); Vcount becomes 1.
REQ-035 Full frame: 525 lines of 800 Clocks each -> Vsync=0 only during lines 490..491 (1600 Clocks); Video_on=0 for lines 480..524; Vcount wraps 524->0; Frame_start high for exactly 1 Clock.
REQ-036 Boundary: Hcount=639 then 640 on line 479 -> Video_on 1 then 0; Row=479 then 0; Col=639 then 0.
REQ-037 Mid-frame reset: assert Clear=0 for one Clock at line 300 -> Vcount=0 with no Frame_start; the next Roll_over gives Vcount=1.
REQ-038 Out-of-range and held input: drive Hcount=900 -> Video_on=0, Hsync=1; hold Roll_over=1 for 3 Clocks -> Vcount advances by 3.
